pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and fetch-control stage directly upstream of instruction_memory.
//  Holds the PC, selects the next PC (sequential/branch/jalr/hold), drives the fetch
//  address into instruction_memory.A and flags when that fetch is valid.
//  Detects misaligned and out-of-range targets, supports stall and halt, and counts
//  retired instructions. Single-cycle core: one instruction per un-stalled RUN cycle.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset; base of instruction memory
//  IMEM_DEPTH    16             instruction memory size in 32-bit words
// PORTS
//  clk            in   1   single clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hold PC and state this cycle; no retire counted
//  halt_req       in   1   current instruction is ECALL/EBREAK: stop after it retires
//  pc_src         in   2   00 pc+4, 01 pc_target, 10 jalr_target, 11 hold
//  pc_target      in   32  branch/JAL target (pc+imm computed outside)
//  jalr_target    in   32  rs1+imm from ALU; bit 0 cleared internally
//  pc             out  32  current PC, feeds instruction_memory.A
//  pc_plus4       out  32  pc+4 (combinational, mod 2^32), for JAL/JALR link
//  fetch_valid    out  1   1 only in RUN: instruction at pc is executing
//  halted         out  1   1 in HALT state
//  fault          out  1   1 in FAULT state
//  fault_addr     out  32  offending next-PC captured on fault entry
//  instr_count    out  32  retired-instruction counter, saturating
// BEHAVIOUR
//  Reset (rst=1 at edge, from any state, mid-operation included): state=BOOT,
//   pc=RESET_VECTOR, fetch_valid=0, halted=0, fault=0, fault_addr=0, instr_count=0.
//  States: BOOT -> RUN -> {HALT | FAULT}; HALT and FAULT exit only via rst.
//  BOOT: one cycle, pc held at RESET_VECTOR, fetch_valid=0; next edge -> RUN.
//  RUN (fetch_valid=1), priority per edge, highest first:
//   1. stall=1: pc, state, counter unchanged; halt_req and pc_src ignored.
//   2. halt_req=1: instr_count+=1, state->HALT, pc unchanged (halt wins over redirect).
//   3. else compute next_pc from pc_src; jalr path uses {jalr_target[31:1],1'b0}.
//      pc_src=11: pc unchanged, still counts as retire.
//   4. if next_pc[1:0]!=0 OR next_pc<RESET_VECTOR OR
//      next_pc>=RESET_VECTOR+4*IMEM_DEPTH: state->FAULT, fault_addr=next_pc,
//      pc unchanged, instr_count+=1 (faulting-redirect instruction did retire).
//   5. else pc<=next_pc, instr_count+=1.
//  Range comparison done in 33 bits: pc+4 wrap at 32'hFFFF_FFFC yields 0 and is
//   checked as such (faults unless 0 lies in range).
//  instr_count saturates at 32'hFFFF_FFFF; never wraps.
//  HALT/FAULT: fetch_valid=0, pc, fault_addr, instr_count frozen; all inputs ignored.
//  pc_plus4 always = pc+4 regardless of state. Latency: redirect visible on pc
//   the cycle after the edge that samples pc_src.
// TESTING
//  rst 1 cycle, RESET_VECTOR=0 -> pc=0, fetch_valid=0 in BOOT, =1 next cycle, count=0.
//  pc_src=00 for 5 RUN cycles -> pc 0,4,8,12,16,20; instr_count=5.
//  pc=8, pc_src=01 pc_target=0x20 -> pc=0x20; pc_src=10 jalr_target=0x0D -> pc=0x0C.
//  pc=4, pc_src=01 pc_target=0x06 -> fault=1, fault_addr=6, pc stays 4;
//   pc_target=0x40 (IMEM_DEPTH=16) -> fault, fault_addr=0x40.
//  stall=1 with halt_req=1 and pc_src=01 for 3 cycles -> pc/count unchanged, no HALT;
//   drop stall -> HALT, count+1, pc unchanged, fetch_valid=0.
//  rst asserted in HALT and in FAULT -> next edge BOOT, pc=RESET_VECTOR, flags and count 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control for a single-cycle core.
// Holds the PC, picks the next PC, rejects misaligned or out-of-range
// targets, and counts retired instructions with saturation.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_req,
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Legal fetch window, widened to 33 bits so a window ending at 2^32
  // and a pc+4 that wrapped to zero are both compared correctly.
  localparam logic [32:0] RANGE_LO = {1'b0, RESET_VECTOR};
  localparam logic [32:0] RANGE_HI = RANGE_LO + 33'(4 * IMEM_DEPTH);

  state_t      state;
  state_t      state_nx;
  logic [31:0] next_pc;
  logic [31:0] jalr_aligned;
  logic        bad_target;
  logic        retire;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc_plus4     = pc + 32'd4;
  assign jalr_aligned = jalr_target & 32'hFFFF_FFFE;
  assign retire       = (state == S_RUN) && !stall;

  // Next-PC selection and target legality check.
  always_comb begin
    next_pc = pc;
    unique case (pc_src)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = pc_target;
      2'b10:   next_pc = jalr_aligned;
      default: next_pc = pc;
    endcase
    bad_target = (next_pc[1:0] != 2'b00)
              || ({1'b0, next_pc} <  RANGE_LO)
              || ({1'b0, next_pc} >= RANGE_HI);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nx;
  end

  // Next-state logic: halt beats redirect, stall beats everything.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_BOOT: state_nx = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (halt_req)        state_nx = S_HALT;
          else if (bad_target) state_nx = S_FAULT;
        end
      end
      default: state_nx = state;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    fetch_valid = (state == S_RUN);
    halted      = (state == S_HALT);
    fault       = (state == S_FAULT);
  end

  // PC, fault address and retire counter; frozen outside an un-stalled RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      fault_addr  <= 32'd0;
      instr_count <= 32'd0;
    end else if (retire) begin
      instr_count <= sat_inc(instr_count);
      if (!halt_req) begin
        if (bad_target) fault_addr <= next_pc;
        else            pc         <= next_pc;
      end
    end
  end

endmodule
